// File: rtl/spi_master_packet_collector.sv
// Passive SPI master snooper: splits each chip-select frame into command, address
// and MOSI-data fields and presents one packet per frame on a valid/ready port.
module spi_master_packet_collector #(
    parameter int CMD_W  = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        spi_sclk,
    input  logic                        spi_csn,
    input  logic [3:0]                  spi_sdo,
    input  logic                        cfg_quad,
    input  logic [$clog2(CMD_W+1)-1:0]  cfg_cmd_len,
    input  logic [$clog2(ADDR_W+1)-1:0] cfg_addr_len,
    input  logic [$clog2(DATA_W+1)-1:0] cfg_data_len,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic [CMD_W-1:0]            pkt_cmd,
    output logic [ADDR_W-1:0]           pkt_addr,
    output logic [DATA_W-1:0]           pkt_data,
    output logic [CNT_W-1:0]            pkt_bits,
    output logic [1:0]                  pkt_flag,
    output logic [7:0]                  drop_cnt
);
    localparam int CL_W = $clog2(CMD_W+1);
    localparam int AL_W = $clog2(ADDR_W+1);
    localparam int DL_W = $clog2(DATA_W+1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_TAIL} state_t;

    logic [1:0] sclk_sq, csn_sq, sync_ok_q;
    logic [3:0] sdo1_q, sdo2_q;
    logic       sclk_prev_q, csn_prev_q, armed_q;
    logic       sample, csn_fall, csn_rise;

    state_t              state_q, state_d;
    logic                quad_q, quad_d, ovf_q, ovf_d;
    logic [CL_W-1:0]     cmd_len_q, cmd_len_d, cmd_cnt_q, cmd_cnt_d;
    logic [AL_W-1:0]     addr_len_q, addr_len_d, addr_cnt_q, addr_cnt_d;
    logic [DL_W-1:0]     data_len_q, data_len_d, data_cnt_q, data_cnt_d;
    logic [CMD_W-1:0]    cmd_f_q, cmd_f_d;
    logic [ADDR_W-1:0]   addr_f_q, addr_f_d;
    logic [DATA_W-1:0]   data_f_q, data_f_d;
    logic [CNT_W-1:0]    bits_q, bits_d;

    logic                valid_q, valid_d;
    logic [CMD_W-1:0]    pcmd_q, pcmd_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pdata_q, pdata_d;
    logic [CNT_W-1:0]    pbits_q, pbits_d;
    logic [1:0]          pflag_q, pflag_d;
    logic [7:0]          drop_q, drop_d;

    logic [31:0]         rem;
    logic [2:0]          n, step;
    logic [3:0]          take;
    logic [CNT_W:0]      bits_sum;
    logic                emit, short_frame;

    // Capture is armed only once the synchroniser has seen the real CSN high,
    // so a reset released mid-frame never starts on a half-seen frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sq     <= 2'b00;
            csn_sq      <= 2'b11;
            sdo1_q      <= '0;
            sdo2_q      <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
            sync_ok_q   <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sclk_sq     <= {sclk_sq[0], spi_sclk};
            csn_sq      <= {csn_sq[0], spi_csn};
            sdo1_q      <= spi_sdo;
            sdo2_q      <= sdo1_q;
            sclk_prev_q <= sclk_sq[1];
            csn_prev_q  <= csn_sq[1];
            sync_ok_q   <= {sync_ok_q[0], 1'b1};
            armed_q     <= armed_q | (sync_ok_q[1] & csn_sq[1]);
        end
    end

    assign sample   = sclk_sq[1] & ~sclk_prev_q & ~csn_sq[1];
    assign csn_fall = armed_q & csn_prev_q & ~csn_sq[1];
    assign csn_rise = ~csn_prev_q & csn_sq[1];

    function automatic state_t next_phase(input logic addr_nz, input logic data_nz);
        if (addr_nz)      return S_ADDR;
        else if (data_nz) return S_DATA;
        else              return S_TAIL;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            quad_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cmd_len_q  <= '0;
            addr_len_q <= '0;
            data_len_q <= '0;
            cmd_cnt_q  <= '0;
            addr_cnt_q <= '0;
            data_cnt_q <= '0;
            cmd_f_q    <= '0;
            addr_f_q   <= '0;
            data_f_q   <= '0;
            bits_q     <= '0;
            valid_q    <= 1'b0;
            pcmd_q     <= '0;
            paddr_q    <= '0;
            pdata_q    <= '0;
            pbits_q    <= '0;
            pflag_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            quad_q     <= quad_d;
            ovf_q      <= ovf_d;
            cmd_len_q  <= cmd_len_d;
            addr_len_q <= addr_len_d;
            data_len_q <= data_len_d;
            cmd_cnt_q  <= cmd_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            data_cnt_q <= data_cnt_d;
            cmd_f_q    <= cmd_f_d;
            addr_f_q   <= addr_f_d;
            data_f_q   <= data_f_d;
            bits_q     <= bits_d;
            valid_q    <= valid_d;
            pcmd_q     <= pcmd_d;
            paddr_q    <= paddr_d;
            pdata_q    <= pdata_d;
            pbits_q    <= pbits_d;
            pflag_q    <= pflag_d;
            drop_q     <= drop_d;
        end
    end

    // A quad sample never spills into the next phase: the last one of a phase
    // keeps only the upper lanes still needed.
    always_comb begin
        rem = '0;
        case (state_q)
            S_CMD:   rem = 32'(cmd_len_q)  - 32'(cmd_cnt_q);
            S_ADDR:  rem = 32'(addr_len_q) - 32'(addr_cnt_q);
            S_DATA:  rem = 32'(data_len_q) - 32'(data_cnt_q);
            default: rem = '0;
        endcase
        n        = !quad_q ? 3'd1 : (rem >= 32'd4) ? 3'd4 : rem[2:0];
        take     = quad_q ? (sdo2_q >> (3'd4 - n)) : {3'b000, sdo2_q[0]};
        step     = quad_q ? 3'd4 : 3'd1;
        bits_sum = {1'b0, bits_q} + (CNT_W+1)'(step);
    end

    assign short_frame = (cmd_cnt_q < cmd_len_q) | (addr_cnt_q < addr_len_q) |
                         (data_cnt_q < data_len_q);

    always_comb begin
        state_d    = state_q;
        quad_d     = quad_q;
        ovf_d      = ovf_q;
        cmd_len_d  = cmd_len_q;
        addr_len_d = addr_len_q;
        data_len_d = data_len_q;
        cmd_cnt_d  = cmd_cnt_q;
        addr_cnt_d = addr_cnt_q;
        data_cnt_d = data_cnt_q;
        cmd_f_d    = cmd_f_q;
        addr_f_d   = addr_f_q;
        data_f_d   = data_f_q;
        bits_d     = bits_q;
        emit       = 1'b0;

        if (state_q == S_IDLE) begin
            if (csn_fall) begin
                quad_d     = cfg_quad;
                cmd_len_d  = cfg_cmd_len;
                addr_len_d = cfg_addr_len;
                data_len_d = cfg_data_len;
                cmd_cnt_d  = '0;
                addr_cnt_d = '0;
                data_cnt_d = '0;
                cmd_f_d    = '0;
                addr_f_d   = '0;
                data_f_d   = '0;
                bits_d     = '0;
                ovf_d      = 1'b0;
                state_d    = (cfg_cmd_len != '0) ? S_CMD :
                             next_phase(cfg_addr_len != '0, cfg_data_len != '0);
            end
        end else if (csn_rise) begin
            emit    = (bits_q != '0);
            state_d = S_IDLE;
        end else if (sample) begin
            bits_d = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
            case (state_q)
                S_CMD: begin
                    cmd_f_d   = (cmd_f_q << n) | CMD_W'(take);
                    cmd_cnt_d = cmd_cnt_q + CL_W'(n);
                    if (cmd_cnt_d == cmd_len_q)
                        state_d = next_phase(addr_len_q != '0, data_len_q != '0);
                end
                S_ADDR: begin
                    addr_f_d   = (addr_f_q << n) | ADDR_W'(take);
                    addr_cnt_d = addr_cnt_q + AL_W'(n);
                    if (addr_cnt_d == addr_len_q)
                        state_d = next_phase(1'b0, data_len_q != '0);
                end
                S_DATA: begin
                    data_f_d   = (data_f_q << n) | DATA_W'(take);
                    data_cnt_d = data_cnt_q + DL_W'(n);
                    if (data_cnt_d == data_len_q)
                        state_d = S_TAIL;
                end
                default: ovf_d = 1'b1;
            endcase
        end
    end

    // A completing packet may load in the same cycle the old one is taken.
    always_comb begin
        valid_d = valid_q;
        pcmd_d  = pcmd_q;
        paddr_d = paddr_q;
        pdata_d = pdata_q;
        pbits_d = pbits_q;
        pflag_d = pflag_q;
        drop_d  = drop_q;
        if (emit) begin
            if (!valid_q || pkt_ready) begin
                valid_d = 1'b1;
                pcmd_d  = cmd_f_q;
                paddr_d = addr_f_q;
                pdata_d = data_f_q;
                pbits_d = bits_q;
                pflag_d = {ovf_q, short_frame};
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (valid_q && pkt_ready) begin
            valid_d = 1'b0;
        end
    end

    assign pkt_valid = valid_q;
    assign pkt_cmd   = pcmd_q;
    assign pkt_addr  = paddr_q;
    assign pkt_data  = pdata_q;
    assign pkt_bits  = pbits_q;
    assign pkt_flag  = pflag_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_spi_master_packet_collector.sv
// Directed plus randomized frames against a field-level model of the collector.
module tb_spi_master_packet_collector;
    logic        clk = 1'b0;
    logic        rst, spi_sclk, spi_csn, cfg_quad, pkt_ready, pkt_valid;
    logic [3:0]  spi_sdo;
    logic [5:0]  cfg_cmd_len, cfg_addr_len;
    logic [6:0]  cfg_data_len;
    logic [31:0] pkt_cmd, pkt_addr;
    logic [63:0] pkt_data;
    logic [15:0] pkt_bits;
    logic [1:0]  pkt_flag;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] cmd;
        logic [63:0] addr;
        logic [63:0] data;
        logic [15:0] bits;
        logic [1:0]  flag;
    } pkt_t;

    spi_master_packet_collector #(.CMD_W(32), .ADDR_W(32), .DATA_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_sdo(spi_sdo),
        .cfg_quad(cfg_quad), .cfg_cmd_len(cfg_cmd_len), .cfg_addr_len(cfg_addr_len),
        .cfg_data_len(cfg_data_len), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_cmd(pkt_cmd), .pkt_addr(pkt_addr), .pkt_data(pkt_data), .pkt_bits(pkt_bits),
        .pkt_flag(pkt_flag), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mask64(input int len);
        if (len >= 64) return '1;
        return (64'd1 << len) - 64'd1;
    endfunction

    // Each phase occupies ceil(len/lanes) samples; a truncated phase yields the
    // leading bits actually sent, right-aligned; samples past all phases overflow.
    function automatic pkt_t model(input bit quad, input int cl, input int al, input int dl,
                                   input logic [63:0] c, input logic [63:0] a,
                                   input logic [63:0] d, input int ns);
        int k, s, nsp, used, b;
        int lens[3];
        logic [63:0] v[3];
        logic [63:0] f[3];
        bit sh;
        pkt_t p;
        k = quad ? 4 : 1;
        lens = '{cl, al, dl};
        v = '{c, a, d};
        s = ns;
        sh = 1'b0;
        for (int ph = 0; ph < 3; ph++) begin
            nsp  = (lens[ph] + k - 1) / k;
            used = (s < nsp) ? s : nsp;
            s    = s - used;
            b    = (used * k > lens[ph]) ? lens[ph] : used * k;
            f[ph] = (b == 0) ? 64'd0 : (v[ph] >> (lens[ph] - b));
            if (b < lens[ph]) sh = 1'b1;
        end
        p.cmd  = f[0];
        p.addr = f[1];
        p.data = f[2];
        p.bits = 16'(ns * k);
        p.flag = {(s > 0), sh};
        return p;
    endfunction

    task automatic spi_sample(input logic [3:0] val);
        spi_sdo = val;
        #20 spi_sclk = 1'b1;
        #40 spi_sclk = 1'b0;
        #20;
    endtask

    task automatic drive_frame(input bit quad, input int cl, input int al, input int dl,
                               input logic [63:0] c, input logic [63:0] a, input logic [63:0] d,
                               input int delta, input bit chk_lat, output pkt_t e);
        int k, nsp, bp, ns;
        int lens[3];
        logic [63:0] v[3];
        logic [3:0] q[$];
        logic [3:0] smp;
        k = quad ? 4 : 1;
        lens = '{cl, al, dl};
        v = '{c & mask64(cl), a & mask64(al), d & mask64(dl)};
        for (int ph = 0; ph < 3; ph++) begin
            nsp = (lens[ph] + k - 1) / k;
            for (int i = 0; i < nsp; i++) begin
                smp = 4'($urandom);
                if (quad) begin
                    for (int j = 0; j < 4; j++) begin
                        bp = lens[ph] - 1 - (i * 4 + j);
                        if (bp >= 0) smp[3-j] = v[ph][bp];
                    end
                end else begin
                    smp[0] = v[ph][lens[ph] - 1 - i];
                end
                q.push_back(smp);
            end
        end
        ns = q.size() + delta;
        if (ns < 1) ns = 1;
        while (q.size() < ns) q.push_back(4'($urandom));
        cfg_quad     = quad;
        cfg_cmd_len  = 6'(cl);
        cfg_addr_len = 6'(al);
        cfg_data_len = 7'(dl);
        #50 spi_csn = 1'b0;
        #40;
        for (int i = 0; i < ns; i++) spi_sample(q[i]);
        #20;
        @(posedge clk);
        #1 spi_csn = 1'b1;
        if (chk_lat) begin
            repeat (2) @(posedge clk);
            #1 chk("lat_early", 64'(pkt_valid), 64'd0);
            @(posedge clk);
            #1 chk("lat_valid", 64'(pkt_valid), 64'd1);
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end
        e = model(quad, cl, al, dl, v[0], v[1], v[2], ns);
    endtask

    task automatic check_pkt(input string tag, input pkt_t e);
        chk({tag, "_cmd"},  64'(pkt_cmd),  e.cmd);
        chk({tag, "_addr"}, 64'(pkt_addr), e.addr);
        chk({tag, "_data"}, pkt_data,      e.data);
        chk({tag, "_bits"}, 64'(pkt_bits), 64'(e.bits));
        chk({tag, "_flag"}, 64'(pkt_flag), 64'(e.flag));
    endtask

    task automatic accept();
        @(negedge clk) pkt_ready = 1'b1;
        @(posedge clk);
        #1 chk("valid_after_handshake", 64'(pkt_valid), 64'd0);
        @(negedge clk) pkt_ready = 1'b0;
    endtask

    initial begin
        pkt_t e, ea, er;
        bit rq;
        rst = 1'b1; spi_sclk = 1'b0; spi_csn = 1'b1; spi_sdo = '0; pkt_ready = 1'b0;
        cfg_quad = 1'b0; cfg_cmd_len = '0; cfg_addr_len = '0; cfg_data_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(pkt_valid), 64'd0);
        check_pkt("rst", '{64'd0, 64'd0, 64'd0, 16'd0, 2'b00});
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);

        drive_frame(1'b0, 8, 24, 32, 64'h9F, 64'h001234, 64'hDEADBEEF, 0, 1'b1, e);
        check_pkt("single", '{64'h9F, 64'h001234, 64'hDEADBEEF, 16'd64, 2'b00});
        accept();

        drive_frame(1'b1, 8, 0, 16, 64'hEB, 64'h0, 64'h1234, 0, 1'b1, e);
        check_pkt("quad", '{64'hEB, 64'h0, 64'h1234, 16'd24, 2'b00});
        accept();

        drive_frame(1'b0, 8, 8, 16, 64'h03, 64'hA5, 64'h5555, -20, 1'b1, e);
        check_pkt("short", '{64'h03, 64'hA, 64'h0, 16'd12, 2'b01});
        accept();

        drive_frame(1'b0, 8, 0, 8, 64'h5A, 64'h0, 64'hC3, 4, 1'b1, e);
        check_pkt("ovf", '{64'h5A, 64'h0, 64'hC3, 16'd20, 2'b10});
        accept();

        drive_frame(1'b0, 8, 8, 8, 64'h11, 64'h22, 64'h33, 0, 1'b1, ea);
        drive_frame(1'b0, 8, 8, 8, 64'h44, 64'h55, 64'h66, 0, 1'b0, e);
        drive_frame(1'b0, 8, 8, 8, 64'h77, 64'h88, 64'h99, 0, 1'b0, e);
        check_pkt("held", '{64'h11, 64'h22, 64'h33, 16'd24, 2'b00});
        chk("drop_cnt", 64'(drop_cnt), 64'd2);
        chk("held_valid", 64'(pkt_valid), 64'd1);
        accept();

        cfg_quad = 1'b0; cfg_cmd_len = 6'd8; cfg_addr_len = 6'd24; cfg_data_len = 7'd32;
        #50 spi_csn = 1'b0;
        #40;
        for (int i = 0; i < 12; i++) spi_sample(4'($urandom));
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) spi_sample(4'($urandom));
        #20 spi_csn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rstmid_valid", 64'(pkt_valid), 64'd0);
        check_pkt("rstmid", '{64'd0, 64'd0, 64'd0, 16'd0, 2'b00});
        chk("rstmid_drop", 64'(drop_cnt), 64'd0);
        drive_frame(1'b0, 8, 24, 32, 64'h9F, 64'h001234, 64'hDEADBEEF, 0, 1'b1, e);
        check_pkt("after_rst", '{64'h9F, 64'h001234, 64'hDEADBEEF, 16'd64, 2'b00});
        accept();

        for (int r = 0; r < 16; r++) begin
            rq = 1'($urandom);
            drive_frame(rq, $urandom_range(0, 32), $urandom_range(0, 32), $urandom_range(0, 64),
                        {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                        $urandom_range(0, 6) - 3, 1'b1, er);
            check_pkt("rand", er);
            accept();
        end
        chk("final_drop", 64'(drop_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_master_packet_collector.md
# spi_master_packet_collector

Parametrised RTL collector that passively snoops the SPI master pins of the subsystem, splits each chip-select frame into command, address and MOSI-data fields with runtime-programmable lengths, and emits one packet per frame over a valid/ready interface. Supports single-lane and quad-lane framing, reports short and overflowing frames, and counts packets dropped under back-pressure. It sits beside the SPI master as the hardware counterpart of the verification collector, feeding a scoreboard FIFO or a register-mapped capture buffer.

## Interface
Parameters:
- CMD_W, 32, maximum command field width in bits
- ADDR_W, 32, maximum address field width in bits
- DATA_W, 64, maximum MOSI data field width in bits
- CNT_W, 16, width of the bit counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- spi_sclk  in  1  SPI clock, asynchronous to clk
- spi_csn  in  1  chip select, active low
- spi_sdo  in  4  MOSI lanes; lane 0 only in single mode
- cfg_quad  in  1  1 = four bits per SCLK edge
- cfg_cmd_len  in  $clog2(CMD_W+1)  command length in bits
- cfg_addr_len  in  $clog2(ADDR_W+1)  address length in bits
- cfg_data_len  in  $clog2(DATA_W+1)  data length in bits
- pkt_valid  out  1  packet available
- pkt_ready  in  1  consumer accepts the packet
- pkt_cmd  out  CMD_W  command, right-aligned
- pkt_addr  out  ADDR_W  address, right-aligned
- pkt_data  out  DATA_W  data, right-aligned
- pkt_bits  out  CNT_W  total bits sampled in the frame
- pkt_flag  out  2  bit0 short frame, bit1 overflow
- drop_cnt  out  8  saturating count of dropped packets

## Operation
- spi_sclk, spi_csn and spi_sdo pass through 2-flop synchronisers. A sample is taken on the synchronised SCLK rising edge while synchronised CSN is low.
- Config is latched on the synchronised CSN falling edge. Changes during a frame are ignored.
- Each sample contributes 1 bit (sdo[0]), or 4 bits MSB-first (sdo[3] first) when quad mode is set.
- FSM states:
  - IDLE: on CSN fall, go to CMD. If cmd_len=0 go to ADDR instead; if addr_len=0 too, go to DATA.
  - CMD, ADDR, DATA: each shifts into its own field until its configured count is reached, then moves to the next non-zero phase.
  - DATA complete: go to TAIL.
  - TAIL: any further sample sets overflow. Those bits are counted in pkt_bits but not stored.
- Quad mode with a length that is not a multiple of 4: the final sample of that phase keeps only the upper (MSB) lanes needed, and the remaining lanes are discarded.
- Frame end (synchronised CSN rise):
  - If no samples were taken, return to IDLE and emit nothing.
  - Otherwise build the packet. Set short if any configured phase is incomplete; partial fields are right-aligned. Return to IDLE.
- Output register:
  - pkt_valid and all payload outputs hold stable until pkt_valid && pkt_ready.
  - If a new packet completes while pkt_valid is high and pkt_ready is low, the new packet is dropped and drop_cnt increments, saturating at 255.
  - If pkt_ready is high in the same cycle a new packet completes, the old packet transfers and the new one loads. No drop occurs.
- pkt_bits saturates at 2^CNT_W-1.

## Timing
- Reset values: pkt_valid=0, pkt_cmd/pkt_addr/pkt_data/pkt_bits=0, pkt_flag=0, drop_cnt=0, FSM=IDLE, synchronisers=idle (CSN=1, SCLK=0).
- Reset mid-frame aborts the frame and emits nothing. Capture restarts only at the next CSN fall after reset release.
- Required ratio: clk ≥ 4× spi_sclk, and CSN high time ≥ 2 clk.
- Latency: pkt_valid rises 3 clk after the raw CSN rise (2 synchroniser stages plus 1 register).
- pkt_valid falls in the cycle after the handshake. A consumer holding pkt_ready high accepts one packet per frame with no bubble.

## Test plan
- Single mode, cmd_len=8, addr_len=24, data_len=32, bits 0x9F/0x001234/0xDEADBEEF -> pkt_cmd=0x9F, pkt_addr=0x001234, pkt_data=0xDEADBEEF, pkt_bits=64, flag=00.
- Quad mode, cmd_len=8, addr_len=0, data_len=16, nibbles E,B,1,2,3,4 -> pkt_cmd=0xEB, pkt_addr=0, pkt_data=0x1234, pkt_bits=24, flag=00.
- Single mode 8/8/16, CSN raised after 12 bits (cmd 0x03, addr bits 0xA) -> pkt_cmd=0x03, pkt_addr=0xA, pkt_data=0, pkt_bits=12, flag=01.
- Single mode 8/0/8, 20 bits sent -> pkt_bits=20, flag=10, pkt_data holds only the first 8 data bits.
- pkt_ready=0 across three complete frames -> first packet held unchanged, drop_cnt=2. Then pulse pkt_ready -> pkt_valid=0 in the next cycle.
- Reset asserted mid-address phase, then CSN raised -> no pkt_valid, all outputs 0. The next full frame is captured correctly.
